// File: rtl/lbp_stream_engine_if.sv
// Bundle of the pixel-ROM read port and the LBP result-RAM write port of
// lbp_stream_engine.
//   gray_ready  1   ROM available / run enable (0 = freeze)
//   gray_data   DW  ROM read data, one cycle after gray_req/gray_addr
//   thr         DW  compare threshold, sampled at frame start
//   gray_req    1   read strobe
//   gray_addr   AW  read address (row*IMG_W + col)
//   lbp_valid   1   result write strobe
//   lbp_addr    AW  result address
//   lbp_data    8   LBP code
//   finish      1   frame complete (level)
// modport master: engine side; modport slave: ROM/RAM/environment side.
interface lbp_stream_engine_if #(
    parameter int DW = 8,
    parameter int AW = 14
);
    logic          gray_ready;
    logic [DW-1:0] gray_data;
    logic [DW-1:0] thr;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic          lbp_valid;
    logic [AW-1:0] lbp_addr;
    logic [7:0]    lbp_data;
    logic          finish;

    modport master (
        input  gray_ready, gray_data, thr,
        output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
    );

    modport slave (
        output gray_ready, gray_data, thr,
        input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
    );
endinterface

// File: rtl/lbp_stream_engine.sv
// Streaming 3x3 LBP engine. Reads a gray image from a 1-cycle-latency ROM
// through a sliding column window (9 reads at row start, 3 per code after
// that) and writes the 8-bit code of every interior pixel, in raster order.
// Optionally zero-fills the border addresses after the interior pass.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    lbp_stream_engine_if.master (ROM read port, result write port,
//          gray_ready run/freeze, thr, finish)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for gray_ready to start a frame
// S_FILL   | issuing the 9 reads of a row's first window (column-major)
// S_STEP   | issuing the 3 reads of the next column, window slides left
// S_DRAIN  | no reads; last capture and last interior write complete
// S_BORDER | one zero write per cycle to the border addresses
// S_DONE   | finish held high until reset
module lbp_stream_engine #(
    parameter int IMG_W       = 128,
    parameter int IMG_H       = 128,
    parameter int DW          = 8,
    parameter int AW          = 14,
    parameter int BORDER_FILL = 0
) (
    input  logic                clk,
    input  logic                reset,
    lbp_stream_engine_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_STEP, S_DRAIN, S_BORDER, S_DONE
    } state_t;

    localparam logic [AW-1:0] ONE_A    = AW'(1);
    localparam logic [AW-1:0] W_A      = AW'(IMG_W);
    localparam logic [AW-1:0] W2_A     = AW'(2 * IMG_W);
    localparam logic [AW-1:0] W_M1     = AW'(IMG_W - 1);
    localparam logic [AW-1:0] LAST_C   = AW'(IMG_W - 2);
    localparam logic [AW-1:0] LAST_R   = AW'(IMG_H - 2);
    localparam logic [AW-1:0] BOT_BASE = AW'((IMG_H - 1) * IMG_W);

    state_t        state_q, state_d;
    logic [AW-1:0] r_q, r_d, c_q, c_d;
    logic [AW-1:0] rowb_q, rowb_d;          // (r-1)*IMG_W, top row of window
    logic [1:0]    dr_q, dr_d, dc_q, dc_d;  // read position inside window
    logic [1:0]    ph_q, ph_d;              // border phase
    logic [DW-1:0] thr_q, thr_d;

    // Capture pipeline: describes the ROM word arriving this cycle.
    logic          cap_v_q, cap_v_d;
    logic          cap_fill_q, cap_fill_d;
    logic          cap_last_q, cap_last_d;
    logic [1:0]    cap_dr_q, cap_dr_d, cap_dc_q, cap_dc_d;
    logic [AW-1:0] cap_addr_q, cap_addr_d;

    logic [DW-1:0] win_q [3][3];
    logic [DW-1:0] win_d [3][3];

    logic          gray_req_q, gray_req_d;
    logic [AW-1:0] gray_addr_q, gray_addr_d;
    logic          lbp_valid_q, lbp_valid_d;
    logic [AW-1:0] lbp_addr_q, lbp_addr_d;
    logic [7:0]    lbp_data_q, lbp_data_d;
    logic          finish_q, finish_d;

    logic [7:0]    code;
    logic [DW:0]   ref_v;
    logic [AW-1:0] row_off;

    // Window update for the word arriving this cycle. A STEP's first word
    // also slides the window left by one column.
    always_comb begin
        win_d = win_q;
        if (bus.gray_ready && cap_v_q) begin
            if (cap_fill_q) begin
                win_d[cap_dr_q][cap_dc_q] = bus.gray_data;
            end else if (cap_dr_q == 2'd0) begin
                for (int i = 0; i < 3; i++) begin
                    win_d[i][0] = win_q[i][1];
                    win_d[i][1] = win_q[i][2];
                end
                win_d[0][2] = bus.gray_data;
            end else begin
                win_d[cap_dr_q][2] = bus.gray_data;
            end
        end
    end

    // Compare in DW+1 bits so C+thr above the pixel range never wraps.
    always_comb begin
        ref_v   = {1'b0, win_d[1][1]} + {1'b0, thr_q};
        code[0] = ({1'b0, win_d[0][0]} >= ref_v);
        code[1] = ({1'b0, win_d[0][1]} >= ref_v);
        code[2] = ({1'b0, win_d[0][2]} >= ref_v);
        code[3] = ({1'b0, win_d[1][0]} >= ref_v);
        code[4] = ({1'b0, win_d[1][2]} >= ref_v);
        code[5] = ({1'b0, win_d[2][0]} >= ref_v);
        code[6] = ({1'b0, win_d[2][1]} >= ref_v);
        code[7] = ({1'b0, win_d[2][2]} >= ref_v);
    end

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        c_d         = c_q;
        rowb_d      = rowb_q;
        dr_d        = dr_q;
        dc_d        = dc_q;
        ph_d        = ph_q;
        thr_d       = thr_q;
        cap_v_d     = cap_v_q;
        cap_fill_d  = cap_fill_q;
        cap_last_d  = cap_last_q;
        cap_dr_d    = cap_dr_q;
        cap_dc_d    = cap_dc_q;
        cap_addr_d  = cap_addr_q;
        gray_req_d  = gray_req_q;
        gray_addr_d = gray_addr_q;
        lbp_valid_d = lbp_valid_q;
        lbp_addr_d  = lbp_addr_q;
        lbp_data_d  = lbp_data_q;
        finish_d    = finish_q;
        row_off     = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.gray_ready) begin
                    state_d    = S_FILL;
                    r_d        = ONE_A;
                    c_d        = ONE_A;
                    rowb_d     = '0;
                    dr_d       = 2'd0;
                    dc_d       = 2'd0;
                    thr_d      = bus.thr;
                    gray_req_d = 1'b1;
                end
            end
            S_FILL, S_STEP, S_DRAIN: begin
                if (bus.gray_ready) begin
                    cap_v_d     = 1'b0;
                    lbp_valid_d = 1'b0;
                    if (cap_v_q && cap_last_q) begin
                        lbp_valid_d = 1'b1;
                        lbp_addr_d  = cap_addr_q;
                        lbp_data_d  = code;
                    end
                    if (state_q == S_DRAIN) begin
                        // Leave once the final capture has been turned into a write.
                        if (!cap_v_q) begin
                            if (BORDER_FILL != 0) begin
                                state_d     = S_BORDER;
                                ph_d        = 2'd0;
                                c_d         = '0;
                                lbp_valid_d = 1'b1;
                                lbp_addr_d  = '0;
                                lbp_data_d  = 8'h00;
                            end else begin
                                state_d  = S_DONE;
                                finish_d = 1'b1;
                            end
                        end
                    end else begin
                        cap_v_d    = 1'b1;
                        cap_fill_d = (state_q == S_FILL);
                        cap_dr_d   = dr_q;
                        cap_dc_d   = dc_q;
                        cap_last_d = (dr_q == 2'd2) && (state_q == S_STEP || dc_q == 2'd2);
                        cap_addr_d = rowb_q + W_A + c_q;
                        if (dr_q != 2'd2) begin
                            dr_d = dr_q + 2'd1;
                        end else begin
                            dr_d = 2'd0;
                            if (state_q == S_FILL && dc_q != 2'd2) begin
                                dc_d = dc_q + 2'd1;
                            end else if (c_q != LAST_C) begin
                                state_d = S_STEP;
                                c_d     = c_q + ONE_A;
                                dc_d    = 2'd2;
                            end else if (r_q != LAST_R) begin
                                state_d = S_FILL;
                                r_d     = r_q + ONE_A;
                                rowb_d  = rowb_q + W_A;
                                c_d     = ONE_A;
                                dc_d    = 2'd0;
                            end else begin
                                state_d    = S_DRAIN;
                                gray_req_d = 1'b0;
                            end
                        end
                    end
                end
            end
            S_BORDER: begin
                // Order: row 0, row H-1, then left/right edge of rows 1..H-2.
                // c_q counts columns in phases 0/1, r_q counts rows in 2/3.
                if (bus.gray_ready) begin
                    lbp_valid_d = 1'b1;
                    lbp_data_d  = 8'h00;
                    case (ph_q)
                        2'd0, 2'd1: begin
                            if (c_q == W_M1) begin
                                c_d        = '0;
                                ph_d       = ph_q + 2'd1;
                                r_d        = ONE_A;
                                lbp_addr_d = (ph_q == 2'd0) ? BOT_BASE : W_A;
                            end else begin
                                c_d        = c_q + ONE_A;
                                lbp_addr_d = lbp_addr_q + ONE_A;
                            end
                        end
                        2'd2: begin
                            ph_d       = 2'd3;
                            lbp_addr_d = lbp_addr_q + W_M1;
                        end
                        default: begin
                            if (r_q == LAST_R) begin
                                state_d     = S_DONE;
                                finish_d    = 1'b1;
                                lbp_valid_d = 1'b0;
                            end else begin
                                ph_d       = 2'd2;
                                r_d        = r_q + ONE_A;
                                lbp_addr_d = lbp_addr_q + ONE_A;
                            end
                        end
                    endcase
                end
            end
            default: ;
        endcase

        // Read address follows the next window position; while frozen the
        // inputs are unchanged so the address is simply held.
        if (state_d == S_FILL || state_d == S_STEP) begin
            case (dr_d)
                2'd0:    row_off = '0;
                2'd1:    row_off = W_A;
                default: row_off = W2_A;
            endcase
            gray_addr_d = rowb_d + row_off + c_d + {{(AW-2){1'b0}}, dc_d} - ONE_A;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            r_q         <= ONE_A;
            c_q         <= ONE_A;
            rowb_q      <= '0;
            dr_q        <= 2'd0;
            dc_q        <= 2'd0;
            ph_q        <= 2'd0;
            thr_q       <= '0;
            cap_v_q     <= 1'b0;
            cap_fill_q  <= 1'b0;
            cap_last_q  <= 1'b0;
            cap_dr_q    <= 2'd0;
            cap_dc_q    <= 2'd0;
            cap_addr_q  <= '0;
            win_q       <= '{default: '0};
            gray_req_q  <= 1'b0;
            gray_addr_q <= '0;
            lbp_valid_q <= 1'b0;
            lbp_addr_q  <= '0;
            lbp_data_q  <= 8'h00;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            c_q         <= c_d;
            rowb_q      <= rowb_d;
            dr_q        <= dr_d;
            dc_q        <= dc_d;
            ph_q        <= ph_d;
            thr_q       <= thr_d;
            cap_v_q     <= cap_v_d;
            cap_fill_q  <= cap_fill_d;
            cap_last_q  <= cap_last_d;
            cap_dr_q    <= cap_dr_d;
            cap_dc_q    <= cap_dc_d;
            cap_addr_q  <= cap_addr_d;
            win_q       <= win_d;
            gray_req_q  <= gray_req_d;
            gray_addr_q <= gray_addr_d;
            lbp_valid_q <= lbp_valid_d;
            lbp_addr_q  <= lbp_addr_d;
            lbp_data_q  <= lbp_data_d;
            finish_q    <= finish_d;
        end
    end

    // Strobes are masked while frozen; the held state re-issues them on resume.
    assign bus.gray_req  = gray_req_q & bus.gray_ready;
    assign bus.gray_addr = gray_addr_q;
    assign bus.lbp_valid = lbp_valid_q & bus.gray_ready;
    assign bus.lbp_addr  = lbp_addr_q;
    assign bus.lbp_data  = lbp_data_q;
    assign bus.finish    = finish_q;
endmodule

// File: tb/tb_lbp_stream_engine.sv
// Directed bench for lbp_stream_engine: four instances (4x4, 5x4 with border
// fill, 3x3, 12x7) each with a gated-read ROM model and a write monitor.
module tb_lbp_stream_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       rdy   [4];
    logic [7:0] thr_v [4];
    logic [7:0] mem   [4][128];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int wa [4][$];
    int wd [4][$];
    int wc [4][$];
    int fc [4];
    int ra [$];
    int rc [$];
    int viol = 0;

    localparam int DR [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    localparam int DC [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};

    lbp_stream_engine_if #(.DW(8), .AW(14)) if0 ();
    lbp_stream_engine_if #(.DW(8), .AW(14)) if1 ();
    lbp_stream_engine_if #(.DW(8), .AW(14)) if2 ();
    lbp_stream_engine_if #(.DW(8), .AW(14)) if3 ();

    assign if0.gray_ready = rdy[0];
    assign if1.gray_ready = rdy[1];
    assign if2.gray_ready = rdy[2];
    assign if3.gray_ready = rdy[3];
    assign if0.thr = thr_v[0];
    assign if1.thr = thr_v[1];
    assign if2.thr = thr_v[2];
    assign if3.thr = thr_v[3];

    lbp_stream_engine #(.IMG_W(4), .IMG_H(4), .DW(8), .AW(14), .BORDER_FILL(0))
        dut0 (.clk(clk), .reset(reset), .bus(if0));
    lbp_stream_engine #(.IMG_W(5), .IMG_H(4), .DW(8), .AW(14), .BORDER_FILL(1))
        dut1 (.clk(clk), .reset(reset), .bus(if1));
    lbp_stream_engine #(.IMG_W(3), .IMG_H(3), .DW(8), .AW(14), .BORDER_FILL(0))
        dut2 (.clk(clk), .reset(reset), .bus(if2));
    lbp_stream_engine #(.IMG_W(12), .IMG_H(7), .DW(8), .AW(14), .BORDER_FILL(0))
        dut3 (.clk(clk), .reset(reset), .bus(if3));

    always @(posedge clk) cyc <= cyc + 1;

    // ROM: reads only on an effective strobe, so data holds while frozen.
    always @(posedge clk) begin
        if (if0.gray_req) if0.gray_data <= mem[0][if0.gray_addr[6:0]];
        if (if1.gray_req) if1.gray_data <= mem[1][if1.gray_addr[6:0]];
        if (if2.gray_req) if2.gray_data <= mem[2][if2.gray_addr[6:0]];
        if (if3.gray_req) if3.gray_data <= mem[3][if3.gray_addr[6:0]];
    end

    task automatic mon(input int k, input logic v, input logic [13:0] a,
                       input logic [7:0] d, input logic f);
        if (v === 1'b1) begin
            wa[k].push_back(int'(a));
            wd[k].push_back(int'(d));
            wc[k].push_back(cyc);
        end
        if (f === 1'b1 && fc[k] < 0) fc[k] = cyc;
    endtask

    always @(negedge clk) begin
        mon(0, if0.lbp_valid, if0.lbp_addr, if0.lbp_data, if0.finish);
        mon(1, if1.lbp_valid, if1.lbp_addr, if1.lbp_data, if1.finish);
        mon(2, if2.lbp_valid, if2.lbp_addr, if2.lbp_data, if2.finish);
        mon(3, if3.lbp_valid, if3.lbp_addr, if3.lbp_data, if3.finish);
        if (if0.gray_req === 1'b1) begin
            ra.push_back(int'(if0.gray_addr));
            rc.push_back(cyc);
        end
        if (!rdy[3] && (if3.gray_req === 1'b1 || if3.lbp_valid === 1'b1)) viol++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        for (int k = 0; k < 4; k++) begin
            wa[k].delete();
            wd[k].delete();
            wc[k].delete();
            fc[k] = -1;
        end
        ra.delete();
        rc.delete();
        viol = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) rdy[k] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        clear_logs();
    endtask

    // Starts instance k and waits for finish; fr > 0 drops gray_ready for 3
    // cycles out of every fr.
    task automatic run(input int k, input int maxc, input int fr);
        int i = 0;
        @(posedge clk);
        #1;
        rdy[k] = 1'b1;
        while (fc[k] < 0 && i < maxc) begin
            @(posedge clk);
            #1;
            i++;
            if (fr > 0) rdy[k] = ((i % fr) < fr - 3);
        end
        rdy[k] = 1'b1;
        chk("finish_reached", (fc[k] >= 0) ? 1 : 0, 1);
    endtask

    function automatic int model(input int k, input int w, input int r, input int c, input int t);
        int cen  = int'(mem[k][r*w + c]);
        int code = 0;
        for (int i = 0; i < 8; i++) begin
            int n = int'(mem[k][(r + DR[i])*w + c + DC[i]]);
            if (n >= cen + t) code = code | (1 << i);
        end
        return code;
    endfunction

    task automatic check_frame(input string tg, input int k, input int w, input int h,
                               input int t, input bit border);
        int ea [$];
        int ed [$];
        for (int r = 1; r <= h - 2; r++)
            for (int c = 1; c <= w - 2; c++) begin
                ea.push_back(r*w + c);
                ed.push_back(model(k, w, r, c, t));
            end
        if (border) begin
            for (int c = 0; c < w; c++) begin ea.push_back(c); ed.push_back(0); end
            for (int c = 0; c < w; c++) begin ea.push_back((h-1)*w + c); ed.push_back(0); end
            for (int r = 1; r <= h - 2; r++) begin
                ea.push_back(r*w);       ed.push_back(0);
                ea.push_back(r*w + w-1); ed.push_back(0);
            end
        end
        chk({tg, "_count"}, wa[k].size(), ea.size());
        for (int i = 0; i < ea.size() && i < wa[k].size(); i++) begin
            chk({tg, "_addr"}, wa[k][i], ea[i]);
            chk({tg, "_data"}, wd[k][i], ed[i]);
        end
        if (wc[k].size() > 0) chk({tg, "_fin_lat"}, fc[k] - wc[k][wc[k].size()-1], 1);
    endtask

    initial begin
        int er [$];
        int i;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin rdy[k] = 1'b0; thr_v[k] = 8'h00; end
        clear_logs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gray_req",  if0.gray_req,  0);
        chk("rst_gray_addr", if0.gray_addr, 0);
        chk("rst_lbp_valid", if0.lbp_valid, 0);
        chk("rst_lbp_addr",  if0.lbp_addr,  0);
        chk("rst_lbp_data",  if0.lbp_data,  0);
        chk("rst_finish",    if0.finish,    0);
        reset = 1'b1;

        // T1: uniform 8'h55, thr 0 -> 8'hFF at 5,6,9,10
        for (int a = 0; a < 16; a++) mem[0][a] = 8'h55;
        run(0, 300, 0);
        check_frame("T1", 0, 4, 4, 0, 0);
        chk("T1_d0", wd[0][0], 32'hFF);
        for (int r = 1; r <= 2; r++)
            for (int c = 1; c <= 2; c++)
                if (c == 1) begin
                    for (int dc = -1; dc <= 1; dc++)
                        for (int dr = -1; dr <= 1; dr++) er.push_back((r+dr)*4 + c + dc);
                end else begin
                    for (int dr = -1; dr <= 1; dr++) er.push_back((r+dr)*4 + c + 1);
                end
        chk("T1_rd_count", ra.size(), er.size());
        for (int j = 0; j < er.size() && j < ra.size(); j++) chk("T1_rd_addr", ra[j], er[j]);
        if (rc.size() == 24) chk("T1_rd_b2b", rc[23] - rc[0], 23);
        if (rc.size() > 8 && wc[0].size() > 1) begin
            chk("T1_lat_first", wc[0][0] - rc[8], 2);
            chk("T1_step_rate", wc[0][1] - wc[0][0], 3);
        end
        rdy[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rdy[0] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("T1_done_fin",   if0.finish, 1);
        chk("T1_done_req",   if0.gray_req, 0);
        chk("T1_done_nowr",  wa[0].size(), 4);

        // T2: pixel = index. thr 0 -> 8'hF0 everywhere, thr 5 -> 8'h80.
        do_reset();
        for (int a = 0; a < 16; a++) mem[0][a] = 8'(a);
        thr_v[0] = 8'd0;
        run(0, 300, 0);
        check_frame("T2a", 0, 4, 4, 0, 0);
        chk("T2a_d3", wd[0][3], 32'hF0);
        do_reset();
        thr_v[0] = 8'd5;
        run(0, 300, 0);
        check_frame("T2b", 0, 4, 4, 5, 0);
        chk("T2b_d0", wd[0][0], 32'h80);

        // T6: 3x3, centre FE, neighbours FF, thr 2 -> 8'h00 (no wrap)
        do_reset();
        for (int a = 0; a < 9; a++) mem[2][a] = 8'hFF;
        mem[2][4] = 8'hFE;
        thr_v[2] = 8'h02;
        run(2, 200, 0);
        check_frame("T6", 2, 3, 3, 2, 0);
        chk("T6_d0", wd[2][0], 32'h00);

        // T5: 5x4 random with border fill
        do_reset();
        for (int a = 0; a < 20; a++) mem[1][a] = 8'($urandom_range(0, 255));
        thr_v[1] = 8'h10;
        run(1, 400, 0);
        check_frame("T5", 1, 5, 4, 16, 1);

        // T3: 12x7 random, periodic freezes, thr changed mid-run
        do_reset();
        for (int a = 0; a < 84; a++) mem[3][a] = 8'($urandom_range(0, 255));
        thr_v[3] = 8'd3;
        @(posedge clk);
        #1;
        rdy[3] = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        thr_v[3] = 8'd200;
        run(3, 3000, 20);
        check_frame("T3", 3, 12, 7, 3, 0);
        chk("T3_freeze_quiet", viol, 0);

        // T4: reset mid-row 3, then a full frame from address IMG_W+1
        do_reset();
        thr_v[3] = 8'd7;
        rdy[3] = 1'b1;
        i = 0;
        while (wa[3].size() < 24 && i < 2000) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("T4_mid_reached", (wa[3].size() >= 24) ? 1 : 0, 1);
        reset = 1'b0;
        #1;
        chk("T4_rst_req",    if3.gray_req,  0);
        chk("T4_rst_gaddr",  if3.gray_addr, 0);
        chk("T4_rst_valid",  if3.lbp_valid, 0);
        chk("T4_rst_laddr",  if3.lbp_addr,  0);
        chk("T4_rst_ldata",  if3.lbp_data,  0);
        chk("T4_rst_finish", if3.finish,    0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        clear_logs();
        run(3, 2000, 0);
        check_frame("T4", 3, 12, 7, 7, 0);
        chk("T4_first_addr", wa[3][0], 13);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
